// File: rtl/fabric_uart_rx_if.sv
// Receive stream between fabric_uart_rx and its fabric consumer.
// Carries the head byte of a first-word-fall-through FIFO, the valid/ready pair and the occupancy.
interface fabric_uart_rx_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             RX_READY;
  logic [FIFO_AW:0] FIFO_COUNT;

  modport master (output RX_DATA, RX_VALID, FIFO_COUNT, input RX_READY);
  modport slave  (input RX_DATA, RX_VALID, FIFO_COUNT, output RX_READY);
endinterface

// File: rtl/fabric_uart_rx.sv
// Fabric-side 16x-oversampled UART receiver (8N1) feeding a FWFT byte FIFO with ready/valid output.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop, plus the sticky PARITY_ERR flag.
module fabric_uart_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_AW    = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RXD,
  fabric_uart_rx_if.master rx,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
`ifdef UART_RX_PARITY_EN
  output logic             PARITY_ERR,
`endif
  input  logic             ERR_CLR
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] TICK_LAST = 16'(BAUD_DIV - 1);

  if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud_div
    $error("fabric_uart_rx: BAUD_DIV must be within 2..65535");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("fabric_uart_rx: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam bit PAR_ODD = (PARITY_ODD != 0);
`else
  typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bc_q, bc_d;
  logic [7:0]  shift_q, shift_d;
  logic        rxd_meta, rxd_sync;
  logic [15:0] tick_cnt;
  logic        tick;
  logic        push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d, parity_set;
`endif

  // NOTE: RXD is asynchronous to CLK; only the second flop may feed decisions.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RESET)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_WAIT_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bc_d      = bc_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    if (tick) begin
      unique case (state_q)
        S_WAIT_IDLE: if (rxd_sync) state_d = S_IDLE;
        S_IDLE: begin
          if (!rxd_sync) begin
            state_d = S_START;
            sc_d    = '0;
          end
        end
        // Mid start bit: a line that is already high again was a glitch.
        S_START: begin
          if (sc_q == 4'd7) begin
            sc_d    = '0;
            bc_d    = '0;
            state_d = rxd_sync ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d[bc_q] = rxd_sync;
            bc_d          = bc_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bc_q == 3'd7) state_d = S_PARITY;
`else
            if (bc_q == 3'd7) state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            par_bad_d  = ((^shift_q) ^ rxd_sync) != PAR_ODD;
            parity_set = par_bad_d;
            state_d    = S_STOP;
          end
        end
`endif
        S_STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rxd_sync) begin
`ifdef UART_RX_PARITY_EN
              push_req = !par_bad_q;
`else
              push_req = 1'b1;
`endif
              state_d  = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_WAIT_IDLE;
            end
          end
        end
        default: state_d = S_WAIT_IDLE;
      endcase
    end
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, pop, push, overrun_set;

  assign empty       = (count == '0);
  assign full        = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop         = rx.RX_READY && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push        = push_req && (!full || pop);
  assign overrun_set = push_req && full && !pop;

  // NOTE: storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rx.RX_VALID   = !empty;
  assign rx.RX_DATA    = empty ? 8'h00 : mem[rd_ptr];
  assign rx.FIFO_COUNT = count;

  // Sticky flags: a new event on the clearing cycle wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
    end else begin
      FRAME_ERR <= frame_set   || (FRAME_ERR && !ERR_CLR);
      OVERRUN   <= overrun_set || (OVERRUN && !ERR_CLR);
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= parity_set || (PARITY_ERR && !ERR_CLR);
`endif
    end
  end

endmodule

// File: doc/fabric_uart_rx.md
Name: fabric_uart_rx

Overview:
- Fabric-side UART receiver that terminates the far end of the MSS MMUART_0 transmit line (MMUART_0_TXD_M2F), so fabric logic can consume bytes sent by MSS firmware.
- 16x oversampled, 8N1 framing (parity optional), with a first-word-fall-through receive FIFO and a ready/valid output.
- Sits between the system top-level TXD net and fabric consumers; clocked from the fabric CCC clock.

Parameters:
- BAUD_DIV, 27, clocks per 1/16-bit tick (50 MHz / (115200*16)); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; only used when UART_RX_PARITY_EN is defined.

Ports:
- CLK  input  1  fabric clock.
- RESET  input  1  synchronous, active-high reset.
- RXD  input  1  asynchronous serial line, idle high.
- RX_DATA  output  8  FIFO head byte; valid only while RX_VALID=1.
- RX_VALID  output  1  FIFO non-empty.
- RX_READY  input  1  consumer accepts; pop when RX_VALID & RX_READY.
- FIFO_COUNT  output  FIFO_AW+1  bytes held, 0..2**FIFO_AW.
- FRAME_ERR  output  1  sticky: stop bit sampled low.
- OVERRUN  output  1  sticky: byte completed while FIFO full and no pop in the same cycle.
- ERR_CLR  input  1  clears sticky error flags.

Behaviour:
- Reset: RX_DATA=0, RX_VALID=0, FIFO_COUNT=0, FRAME_ERR=0, OVERRUN=0, tick counter=0, FSM=WAIT_IDLE, synchronizer flops=1, partial byte discarded.
- RXD passes through a 2-FF synchronizer; all FSM decisions use the synced value (2-cycle latency).
- Tick generator: free-running counter 0..BAUD_DIV-1; tick pulses for one cycle when the count equals BAUD_DIV-1, then the counter wraps to 0.
- FSM, tick-driven, with sample counter sc (0..15) and bit counter bc (0..7):
  - WAIT_IDLE: on a tick with RXD=1 -> IDLE. Prevents false start detection after reset, a mid-frame reset, or a break.
  - IDLE: on a tick with RXD=0 -> START, sc=0.
  - START: increment sc on each tick; at sc=7, sample RXD. If 0 -> DATA with sc=0, bc=0. If 1 -> IDLE (glitch; no error raised).
  - DATA: at sc=15, sample RXD into shift[bc] (LSB first). After bc=7 -> STOP (or PARITY when the macro is defined).
  - STOP: at sc=15, sample RXD.
    - If 1: push the byte and go to IDLE.
    - If 0: set FRAME_ERR, discard the byte, go to WAIT_IDLE.
- FIFO, first-word-fall-through:
  - RX_DATA always shows the head byte; RX_VALID=(FIFO_COUNT!=0).
  - A pushed byte is visible on RX_DATA/RX_VALID on the cycle after the push.
  - Pointers wrap modulo 2**FIFO_AW.
- Boundary conditions:
  - Full and push, no pop: byte dropped, OVERRUN set, contents unchanged.
  - Full, push and pop in the same cycle: both happen, no overrun, count stays 2**FIFO_AW.
  - Empty: RX_READY is ignored and the count never underflows.
- Error flags: ERR_CLR=1 clears FRAME_ERR and OVERRUN next cycle. If an error event coincides with ERR_CLR, the set wins.
- RESET mid-frame: same as reset above. The FSM then needs a tick with RXD high before it accepts a new start bit.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at sc=15.
  - Adds output port PARITY_ERR (1 bit, sticky, reset 0, cleared by ERR_CLR with set-wins).
  - Parity mismatch against PARITY_ODD sets PARITY_ERR and discards the byte; the STOP check still runs.
- Not defined: no PARITY state, no PARITY_ERR port, 8N1 only.

Test Plan (BAUD_DIV=4, so 64 clocks per bit):
- Send 0x55 (8N1, valid stop) -> RX_VALID=1 within 620 clocks of the start edge; RX_DATA=0x55; FIFO_COUNT=1; pulse RX_READY -> FIFO_COUNT=0, RX_VALID=0.
- Drive RXD low for 16 clocks only, then high -> FSM returns to IDLE; no push, FRAME_ERR=0; a following 0xC3 is received correctly.
- Send 0xA3 with stop bit 0, then hold RXD low for 3 bit times -> FRAME_ERR=1, FIFO_COUNT=0; RXD high, then send 0x3C -> received as 0x3C. ERR_CLR -> FRAME_ERR=0.
- RX_READY=0; send 17 bytes 0x00..0x10 -> FIFO_COUNT=16, OVERRUN=1; drain yields 0x00..0x0F in order.
- FIFO full; hold RX_READY=1 so the pop coincides with the stop-bit push of 0x7E -> OVERRUN stays 0, count stays 16, 0x7E is last out.
- Assert RESET at data bit 4 while RXD=0, release -> no byte, no error; the FSM waits for RXD high. With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x01 with parity bit 0 -> PARITY_ERR=1, no push.
